// File: rtl/shift_link_pkg.sv
// Shared definitions for the serial shift link (receive and transmit sides).
package shift_link_pkg;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_SHIFTING = 2'd2
  } link_state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived only from the synchronized copy.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic q_sync,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_sync = sync_q[SYNC_STAGES-1];
  assign rise   = q_sync & ~prev_q;
  assign fall   = ~q_sync & prev_q;
endmodule

// File: rtl/input_shift_capture_32.sv
// Receive side of the serial shift link: frames a word between a load strobe
// and WIDTH shift falling edges, then hands it to a valid/ready consumer.
module input_shift_capture_32
  import shift_link_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             load,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_error,
  input  logic             clear_errors
);
  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic             shift_sync, shift_rise_unused, shift_fall;
  logic             load_sync, load_rise_unused, load_fall;
  logic             sin_sync, sin_rise_unused, sin_fall_unused;
  logic [WIDTH-1:0] cap_shifted;
  logic             shift_step, word_done, frame_abort, arm;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_shift (
    .clk(clk), .reset(reset), .d_in(shift),
    .q_sync(shift_sync), .rise(shift_rise_unused), .fall(shift_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .reset(reset), .d_in(load),
    .q_sync(load_sync), .rise(load_rise_unused), .fall(load_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sin (
    .clk(clk), .reset(reset), .d_in(serial_in),
    .q_sync(sin_sync), .rise(sin_rise_unused), .fall(sin_fall_unused)
  );

  logic unused_shift_level;
  assign unused_shift_level = shift_sync;

  // Load has priority over a coincident shift edge while shifting.
  assign arm         = (state_q == ST_IDLE) && load_sync;
  assign frame_abort = (state_q == ST_SHIFTING) && load_sync;
  assign shift_step  = (state_q == ST_SHIFTING) && !load_sync && shift_fall;
  assign word_done   = shift_step && (cnt_q == LAST_CNT);
  assign cap_shifted = {cap_q[WIDTH-2:0], sin_sync};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (load_sync) state_d = ST_ARMED;
      ST_ARMED:    if (load_fall) state_d = ST_SHIFTING;
      ST_SHIFTING: begin
        if (load_sync)      state_d = ST_ARMED;
        else if (word_done) state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SHIFTING);
  end

  always_comb begin
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;

    if (arm || frame_abort) begin
      cap_d = '0;
      cnt_d = '0;
    end else if (shift_step) begin
      cap_d = cap_shifted;
      cnt_d = cnt_q + 1'b1;
    end

    if (valid_q && data_ready) valid_d = 1'b0;

    if (clear_errors) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end

    // A word arriving while the previous one is still unconsumed is dropped.
    if (word_done) begin
      if (valid_q && !data_ready) begin
        ovr_d = 1'b1;
      end else begin
        dout_d  = cap_shifted;
        valid_d = 1'b1;
      end
    end

    if (frame_abort) ferr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      cap_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = valid_q;
  assign overrun     = ovr_q;
  assign frame_error = ferr_q;
endmodule

// File: doc/input_shift_capture_32.md
INPUT_SHIFT_CAPTURE_32 -- requirements
Module: input_shift_capture_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, serial word length in bits (2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on shift, load and serial_in (>=2).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port shift  input  1  link serial clock, asynchronous to clk; the sender updates data on its rising edge.
REQ-006 SHALL have port load  input  1  link frame/load strobe, asynchronous, active-high.
REQ-007 SHALL have port serial_in  input  1  link serial data, MSB first.
REQ-008 SHALL have port data_out  output  WIDTH  last completed word.
REQ-009 SHALL have port data_valid  output  1  data_out holds an unconsumed word.
REQ-010 SHALL have port data_ready  input  1  consumer accepts data_out when data_valid && data_ready.
REQ-011 SHALL have port busy  output  1  high in state SHIFTING.
REQ-012 SHALL have ports overrun and frame_error  output  1 each  sticky error flags.
REQ-013 SHALL have port clear_errors  input  1  synchronous clear of both sticky flags.

Function
REQ-014 SHALL pass shift, load and serial_in through SYNC_STAGES flops; edge detection SHALL use only the synchronized copies.
REQ-015 SHALL implement FSM states IDLE, ARMED and SHIFTING.
REQ-016 IDLE -> ARMED on synchronized load high; the bit counter SHALL clear and the capture register SHALL be zeroed.
REQ-017 ARMED SHALL ignore shift edges; ARMED -> SHIFTING on synchronized load falling.
REQ-018 In SHIFTING, each synchronized shift falling edge SHALL shift capture <= {capture[WIDTH-2:0], serial_in_sync} and increment the counter (width clog2(WIDTH+1)).
REQ-019 When the counter reaches WIDTH, the FSM SHALL copy capture to the holding register, set data_valid, and return to IDLE in the same cycle.
REQ-020 data_valid SHALL rise no later than SYNC_STAGES+2 clk cycles after the WIDTH-th shift falling edge at the pin.
REQ-021 data_valid SHALL clear in the cycle after data_valid && data_ready, unless a new word completes in that same cycle; in that case data_out SHALL take the new word, data_valid SHALL stay high, and overrun SHALL NOT set.
REQ-022 A word completing while data_valid=1 and data_ready=0 SHALL be dropped, SHALL leave data_out unchanged, and SHALL set overrun.
REQ-023 Synchronized load high while in SHIFTING SHALL abort the word, discard the partial capture, set frame_error, and enter ARMED.
REQ-024 Shift edges seen in IDLE SHALL be ignored and SHALL NOT change any output.
REQ-025 If clear_errors and a new error event occur in the same cycle, the error flag SHALL be set.
REQ-026 Correct capture SHALL require shift high and low phases each >= SYNC_STAGES+1 clk periods; shorter phases are outside specification.

Reset
REQ-027 While reset is high: FSM=IDLE, counter=0, capture=0, data_out=0, data_valid=0, busy=0, overrun=0, frame_error=0, synchronizers=0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; after reset releases, capture SHALL resume only after a fresh load pulse.

Structure
REQ-029 The state enum and the default WIDTH constant SHALL live in shared package shift_link_pkg, which the transmit-side block also uses.
REQ-030 Synchronizer plus rise/fall edge detection SHALL be sub-module sync_edge_detect, instantiated once per input (edge outputs unused for serial_in).

Verification
REQ-031 Load pulse, then 32 shift clocks (period 8 clk) carrying 0xA5A50F0F -> data_out=0xA5A50F0F, data_valid high within SYNC_STAGES+2 clk of the last fall, overrun=0.
REQ-032 Two back-to-back words 0x00000001 and 0x80000000 with data_ready held 0 -> data_out=0x00000001, overrun=1; pulse clear_errors -> overrun=0.
REQ-033 Load reasserted after 17 bits of 0xFFFFFFFF, then full word 0x12345678 -> frame_error=1, data_out=0x12345678, no stray bits.
REQ-034 data_ready pulsed in the exact cycle a second word 0xDEADBEEF completes -> data_out=0xDEADBEEF, data_valid stays 1, overrun=0.
REQ-035 Reset asserted after 10 bits, released, then 5 shift edges with no load -> all outputs remain at reset values; a following loaded word 0xCAFEF00D is captured correctly.
REQ-036 Shift edges in IDLE with no load (20 edges, serial_in=1) -> busy=0, data_valid=0, data_out unchanged.
